// File: rtl/dm_byteen_ram_pkg.sv
// Shared types and helpers for the byte-enable data memory.
//   BYTE_LANES  : byte lanes per 32-bit word
//   dm_trace_t  : one committed-store record {pc, word-aligned addr, merged data}
//   byte_merge  : replaces the enabled byte lanes of a word with store data
package dm_pkg;

    localparam int BYTE_LANES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } dm_trace_t;

    function automatic logic [31:0] byte_merge(input logic [31:0]           old_word,
                                               input logic [31:0]           wdata,
                                               input logic [BYTE_LANES-1:0] byteen);
        logic [31:0] result;
        result = old_word;
        for (int k = 0; k < BYTE_LANES; k++) begin
            if (byteen[k]) begin
                result[8*k +: 8] = wdata[8*k +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dm_byteen_ram_if.sv
// Bus between the core data port and the data memory, plus the store-trace
// valid/ready stream.
//   master : core / logger side (drives address, data, byte enables, PC, trace_ready)
//   slave  : memory side (drives read data and the trace head)
interface dm_byteen_ram_if #(
    parameter int CW = 4
);
    logic [31:0]   m_data_addr;
    logic [31:0]   m_data_wdata;
    logic [3:0]    m_data_byteen;
    logic [31:0]   m_inst_addr;
    logic [31:0]   m_data_rdata;
    logic          trace_valid;
    logic          trace_ready;
    logic [31:0]   trace_pc;
    logic [31:0]   trace_addr;
    logic [31:0]   trace_data;
    logic          trace_overflow;
    logic [CW-1:0] trace_count;

    modport master (
        output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
        input  m_data_rdata, trace_valid, trace_pc, trace_addr, trace_data,
               trace_overflow, trace_count
    );

    modport slave (
        input  m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
        output m_data_rdata, trace_valid, trace_pc, trace_addr, trace_data,
               trace_overflow, trace_count
    );
endinterface

// File: rtl/dm_byteen_ram_trace_fifo.sv
// Synchronous valid/ready FIFO of store records with drop-on-full.
//   clk, reset  : clock, synchronous active-high reset (empties FIFO, clears overflow)
//   push        : record offered this cycle
//   push_data   : record to enqueue
//   pop_ready   : consumer accepts the head this cycle
//   head_valid  : head holds a record
//   head_data   : head record, zero while empty
//   overflow    : sticky, a push was dropped because the FIFO was full
//   count       : occupancy
module dm_trace_fifo
    import dm_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  dm_trace_t     push_data,
    input  logic          pop_ready,
    output logic          head_valid,
    output dm_trace_t     head_data,
    output logic          overflow,
    output logic [CW-1:0] count
);
    localparam int PW = $clog2(FIFO_DEPTH);

    dm_trace_t     store [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign pop     = !empty && pop_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            store[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && !push_ok) overflow <= 1'b1;
        end
    end

    // Push into an empty FIFO only becomes visible next cycle (no fall-through).
    assign head_valid = !empty;
    assign head_data  = empty ? '0 : store[rd_ptr];

endmodule

// File: rtl/dm_byteen_ram.sv
// Data memory behind the core data port: 2**AW x 32 words with byte-enable
// read-modify-write, single-cycle clear through a per-word valid bitmap, and a
// trace FIFO recording every committed store.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of dm_byteen_ram_if (core access + trace stream)
module dm_byteen_ram
    import dm_pkg::*;
#(
    parameter int AW         = 12,
    parameter int FIFO_DEPTH = 8,
    parameter int CW         = 4
) (
    input  logic            clk,
    input  logic            reset,
    dm_byteen_ram_if.slave  bus
);
    localparam int ADDR_WORDS = 2**AW;

    logic [31:0]           mem [ADDR_WORDS];
    logic [ADDR_WORDS-1:0] word_valid;
    logic [AW-1:0]         idx;
    logic [31:0]           rd_word;
    logic [31:0]           merged;
    logic                  store_en;
    dm_trace_t             push_rec;
    dm_trace_t             head_rec;

    // Upper address bits are dropped, so addresses alias modulo the array size.
    assign idx      = bus.m_data_addr[AW+1:2];
    // Words never written since reset read as zero; the array itself is not cleared.
    assign rd_word  = word_valid[idx] ? mem[idx] : 32'h0;
    assign merged   = byte_merge(rd_word, bus.m_data_wdata, bus.m_data_byteen);
    assign store_en = !reset && (|bus.m_data_byteen);

    assign bus.m_data_rdata = rd_word;

    always_ff @(posedge clk) begin
        if (store_en) begin
            mem[idx] <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_valid <= '0;
        end else if (store_en) begin
            word_valid[idx] <= 1'b1;
        end
    end

    assign push_rec.pc   = bus.m_inst_addr;
    assign push_rec.addr = bus.m_data_addr & ~32'h3;
    assign push_rec.data = merged;

    dm_trace_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CW         (CW)
    ) u_trace_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (store_en),
        .push_data  (push_rec),
        .pop_ready  (bus.trace_ready),
        .head_valid (bus.trace_valid),
        .head_data  (head_rec),
        .overflow   (bus.trace_overflow),
        .count      (bus.trace_count)
    );

    assign bus.trace_pc   = head_rec.pc;
    assign bus.trace_addr = head_rec.addr;
    assign bus.trace_data = head_rec.data;

endmodule
